// File: rtl/tc_mul_pkg.sv
// Shared definitions for the round-robin multiplier arbiter.
//   A_W / B_W / P_W : operand and product widths (12u x 18s -> 30s)
//   OP_TAG_W        : width of the tag field carried in operand_t; the
//                     top-level TAG_W parameter must match it
//   operand_t       : one queued multiply operation {a, b, tag}
package tc_mul_pkg;

    localparam int A_W      = 12;
    localparam int B_W      = 18;
    localparam int P_W      = 30;
    localparam int OP_TAG_W = 4;

    typedef struct packed {
        logic        [A_W-1:0]      a;
        logic signed [B_W-1:0]      b;
        logic        [OP_TAG_W-1:0] tag;
    } operand_t;

endpackage

// File: rtl/tc_mul_core.sv
// Combinational 12-bit unsigned x 18-bit signed multiplier.
//   a : unsigned operand (zero-extended before the multiply)
//   b : signed operand
//   p : full signed product; the largest magnitude, 4095 * 2^17, fits in
//       30 signed bits, so no bits are lost
module tc_mul_core
    import tc_mul_pkg::*;
(
    input  logic        [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;

    // a is zero-extended so it is never read as negative; b sign-extends.
    assign a_ext = P_W'(a);
    assign b_ext = P_W'(b);
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/tc_mul_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters.
//   ap_clk, ap_rst_n : clock, synchronous active-low reset
//   req_valid/ready  : per-requester handshake (one-hot ready at most)
//   req_a / req_b    : packed per-requester operands (12u / 18s slices)
//   req_tag          : packed per-requester opaque tags
//   res_valid/ready  : result handshake
//   res_p            : signed 30-bit product
//   res_id / res_tag : issuing requester index and its tag
// Two registered stages: S1 (_p1) holds the granted operands, S2 (_p2)
// holds the product. Results leave in issue order.
module tc_mul_arbiter
    import tc_mul_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = OP_TAG_W,
    parameter int ID_W  = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*A_W-1:0]     req_a,
    input  logic [NREQ*B_W-1:0]     req_b,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [P_W-1:0]   res_p,
    output logic [ID_W-1:0]         res_id,
    output logic [TAG_W-1:0]        res_tag
);

    // Search starts one past the last fired requester and wraps; returns
    // {found, winner}.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [ID_W-1:0] ptr);
        logic            found;
        logic [ID_W-1:0] win;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!found && vld[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

    logic [ID_W-1:0]       rr_ptr;
    logic                  gnt_found;
    logic [ID_W-1:0]       gnt_id;
    logic                  adv1;
    logic                  adv2;
    logic                  fire;
    operand_t              sel_op;

    logic                  vld_p1;
    operand_t              op_p1;
    logic [ID_W-1:0]       id_p1;
    logic signed [P_W-1:0] prod_p1;

    logic                  vld_p2;
    logic signed [P_W-1:0] p_p2;
    logic [ID_W-1:0]       id_p2;
    logic [TAG_W-1:0]      tag_p2;

    // Grant and handshake; reset forces req_ready low regardless of state.
    always_comb begin
        {gnt_found, gnt_id} = rr_pick(req_valid, rr_ptr);
        adv2       = !vld_p2 || res_ready;
        adv1       = !vld_p1 || adv2;
        fire       = ap_rst_n && adv1 && gnt_found;
        req_ready  = '0;
        if (fire) begin
            req_ready[gnt_id] = 1'b1;
        end
        sel_op.a   = req_a[gnt_id*A_W +: A_W];
        sel_op.b   = req_b[gnt_id*B_W +: B_W];
        sel_op.tag = req_tag[gnt_id*TAG_W +: TAG_W];
    end

    // ---- S1: granted operands ----
    always_ff @(posedge ap_clk) begin
        if (fire) begin
            op_p1 <= sel_op;
            id_p1 <= gnt_id;
        end
    end

    tc_mul_core u_core (
        .a (op_p1.a),
        .b (op_p1.b),
        .p (prod_p1)
    );

    // ---- S2: product register and control state ----
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            rr_ptr <= ID_W'(NREQ - 1);
            p_p2   <= '0;
            id_p2  <= '0;
            tag_p2 <= '0;
        end else begin
            if (fire) begin
                rr_ptr <= gnt_id;
            end
            if (adv1) begin
                vld_p1 <= fire;
            end
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    p_p2   <= prod_p1;
                    id_p2  <= id_p1;
                    tag_p2 <= op_p1.tag;
                end
            end
        end
    end

    assign res_valid = vld_p2;
    assign res_p     = p_p2;
    assign res_id    = id_p2;
    assign res_tag   = tag_p2;

endmodule

// File: tb/tb_tc_mul_arbiter.sv
// Scoreboard bench for tc_mul_arbiter (NREQ = 4).
module tb_tc_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int TAG_W = 4;
    localparam int ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*12-1:0]   req_a;
    logic [NREQ*18-1:0]   req_b;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [29:0]   res_p;
    logic [ID_W-1:0]      res_id;
    logic [TAG_W-1:0]     res_tag;

    tc_mul_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .res_tag   (res_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint p;
        int     id;
        int     tag;
    } exp_t;

    exp_t   sb[$];
    int     glog[$];
    longint cur_exp[NREQ];
    int     cur_tag[NREQ];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic longint mul_model(input int a, input int b);
        return longint'(a) * longint'(b);
    endfunction

    task automatic set_req(input int i, input int a, input int b, input int tag, input longint e);
        req_a[i*12 +: 12]       = a[11:0];
        req_b[i*18 +: 18]       = b[17:0];
        req_tag[i*TAG_W +: TAG_W] = tag[TAG_W-1:0];
        cur_exp[i] = e;
        cur_tag[i] = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push the expected result at every fired request; reset discards.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            glog.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{cur_exp[i], i, cur_tag[i]});
                    glog.push_back(i);
                end
            end
        end
    end

    // Pop and compare whenever a result transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (((req_ready & ~req_valid) != 0) || ($countones(req_ready) > 1)) begin
                errors++;
                $display("FAIL ready_onehot: actual ready %b valid %b required one-hot subset", req_ready, req_valid);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: actual id %0d p %0d required no result", res_id, res_p);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_p", longint'(res_p), e.p);
                    check("sb_id", longint'(res_id), longint'(e.id));
                    check("sb_tag", longint'(res_tag), longint'(e.tag));
                end
            end
        end
    end

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_exp[i] = 0;
            cur_tag[i] = 0;
        end

        // Reset state
        @(negedge clk);
        check("rst_ready", longint'(req_ready), 0);
        @(negedge clk);
        check("rst_valid", longint'(res_valid), 0);
        check("rst_p", longint'(res_p), 0);
        check("rst_id", longint'(res_id), 0);
        check("rst_tag", longint'(res_tag), 0);

        // Single op from requester 2, two-cycle latency
        step();
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 4095, -131072, 5, -536739840);
        @(negedge clk);
        check("single_ready", longint'(req_ready), 4);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_lat1", longint'(res_valid), 0);
        @(negedge clk);
        check("single_valid", longint'(res_valid), 1);
        check("single_p", longint'(res_p), -536739840);
        check("single_id", longint'(res_id), 2);
        check("single_tag", longint'(res_tag), 5);

        // Zero and sign cases back to back
        step();
        req_valid = 4'b0001;
        set_req(0, 0, 131071, 1, 0);
        step();
        set_req(0, 1, -1, 2, -1);
        step();
        set_req(0, 4095, 131071, 3, 536735745);
        @(negedge clk);
        check("zero_valid", longint'(res_valid), 1);
        check("zero_p", longint'(res_p), 0);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("neg1_valid", longint'(res_valid), 1);
        check("neg1_p", longint'(res_p), -1);
        @(negedge clk);
        check("max_valid", longint'(res_valid), 1);
        check("max_p", longint'(res_p), 536735745);

        // Backpressure with a full pipeline
        step();
        res_ready = 1'b0;
        req_valid = 4'b1010;
        set_req(1, 1000, -500, 7, -500000);
        set_req(3, 2, 3, 9, 6);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", longint'(req_ready), 0);
            check("bp_valid", longint'(res_valid), 1);
            check("bp_p", longint'(res_p), -500000);
            check("bp_id", longint'(res_id), 1);
            check("bp_tag", longint'(res_tag), 7);
            step();
        end
        res_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("rel_valid0", longint'(res_valid), 1);
        step();
        @(negedge clk);
        check("rel_valid1", longint'(res_valid), 1);
        check("rel_id1", longint'(res_id), 3);
        check("rel_p1", longint'(res_p), 6);
        step();
        @(negedge clk);
        check("rel_empty", longint'(res_valid), 0);

        // Reset with S1 and S2 full, then round-robin from requester 0
        step();
        res_ready = 1'b0;
        req_valid = 4'b0100;
        set_req(2, 77, 77, 2, 5929);
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_ready", longint'(req_ready), 0);
        @(negedge clk);
        check("rst2_valid", longint'(res_valid), 0);
        check("rst2_ready2", longint'(req_ready), 0);
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        set_req(0, 10, -20, 10, -200);
        set_req(1, 300, 400, 11, 120000);
        set_req(2, 4095, -1, 12, -4095);
        set_req(3, 2048, 65536, 13, 134217728);
        @(negedge clk);
        check("rst2_after_valid", longint'(res_valid), 0);
        step();
        repeat (5) step();
        req_valid = 4'b0000;
        check("rr_count", longint'(glog.size()), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < glog.size()) begin
                check("rr_order", longint'(glog[k]), longint'(rr_exp[k]));
            end
        end
        repeat (4) step();

        // Random valid/ready traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                int a;
                int b;
                int t;
                a = int'($urandom_range(0, 4095));
                b = int'($urandom_range(0, 262143)) - 131072;
                t = int'($urandom_range(0, 15));
                set_req(i, a, b, t, mul_model(a, b));
            end
            step();
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        repeat (10) step();
        check("drain_empty", longint'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
